vga_fb_arbiter: RTL and testbench

- Owns the single port of the framebuffer RAM and shares it between two requesters: the display scan-out path, driven by the VGA timing generator's xaddr/yaddr/addr_valid, and the CPU peripheral bus.
- Display has absolute priority. The CPU is granted every cycle the display does not fetch.
- Also holds the double-buffered framebuffer base register. The base swaps at vsync assertion so frames never tear.

---
 rtl/vga_fb_arbiter.sv | 107 ++++++++++
 tb/tb_vga_fb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM port arbiter: display scan-out has absolute priority, the CPU
// gets every other cycle. Also holds the tear-free double-buffered frame base.
module vga_fb_arbiter #(
  parameter int H_LINE = 640,
  parameter int V_LINE = 480,
  parameter int PX_W   = 4,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic                       pxclk,
  input  logic                       rst_n,
  input  logic [$clog2(H_LINE)-1:0]  xaddr,
  input  logic [$clog2(V_LINE)-1:0]  yaddr,
  input  logic                       addr_valid,
  input  logic                       vsync,
  output logic [PX_W-1:0]            pixel,
  output logic                       pixel_valid,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [WORD_W-1:0]          cpu_wdata,
  input  logic [WORD_W/8-1:0]        cpu_wstrb,
  output logic                       cpu_gnt,
  output logic                       cpu_rvalid,
  output logic [WORD_W-1:0]          cpu_rdata,
  input  logic                       base_wr,
  input  logic [ADDR_W-1:0]          base_wdata,
  output logic [ADDR_W-1:0]          base_active,
  output logic                       frame_start,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [WORD_W-1:0]          ram_wdata,
  output logic [WORD_W/8-1:0]        ram_wstrb,
  input  logic [WORD_W-1:0]          ram_rdata
);
  localparam int PPW = WORD_W / PX_W;
  localparam int LPW = $clog2(PPW);
  localparam int WPL = H_LINE / PPW;

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} owner_e;

  owner_e                       rd_owner;
  logic                         disp_fetch;
  logic [ADDR_W-1:0]            disp_addr;
  logic [PPW-1:0][PX_W-1:0]     shift_q;
  logic [1:0][LPW-1:0]          sel_pipe;
  logic [2:1]                   vld_pipe;
  logic                         vsync_q;
  logic [ADDR_W-1:0]            base_pending;

  // One fetch per PPW pixels, on the first pixel of each word.
  assign disp_fetch = addr_valid && (xaddr[LPW-1:0] == '0);
  assign disp_addr  = base_active + ADDR_W'(yaddr) * ADDR_W'(WPL)
                    + ADDR_W'(xaddr >> LPW);

  always_comb begin
    cpu_gnt   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wstrb = '0;
    if (rst_n) begin
      if (disp_fetch) begin
        ram_en   = 1'b1;
        ram_addr = disp_addr;
      end else if (cpu_req) begin
        cpu_gnt   = 1'b1;
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_wstrb = cpu_wstrb;
      end
    end
  end

  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      rd_owner     <= OWN_NONE;
      shift_q      <= '0;
      sel_pipe     <= '0;
      vld_pipe     <= '0;
      vsync_q      <= 1'b0;
      base_pending <= '0;
      base_active  <= '0;
    end else begin
      if (disp_fetch)             rd_owner <= OWN_DISP;
      else if (cpu_gnt && !cpu_we) rd_owner <= OWN_CPU;
      else                        rd_owner <= OWN_NONE;
      if (rd_owner == OWN_DISP) shift_q <= ram_rdata;
      vld_pipe <= {vld_pipe[1], addr_valid};
      sel_pipe <= {sel_pipe[0], xaddr[LPW-1:0]};
      vsync_q  <= vsync;
      // Swap takes the old pending value even if base_wr lands this cycle.
      if (frame_start) base_active <= base_pending;
      if (base_wr)     base_pending <= base_wdata;
    end
  end

  assign frame_start = rst_n && vsync && !vsync_q;
  assign cpu_rvalid  = rst_n && (rd_owner == OWN_CPU);
  assign cpu_rdata   = cpu_rvalid ? ram_rdata : '0;
  assign pixel_valid = rst_n && vld_pipe[2];
  assign pixel       = pixel_valid ? shift_q[sel_pipe[1]] : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: RAM model, per-cycle reference model and
// hand-computed literal expectations.
module tb_vga_fb_arbiter;
  logic        pxclk, rst_n;
  logic [9:0]  xaddr;
  logic [8:0]  yaddr;
  logic        addr_valid, vsync;
  logic [3:0]  pixel;
  logic        pixel_valid;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        base_wr;
  logic [15:0] base_wdata, base_active;
  logic        frame_start;
  logic        ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata;

  int n_vec = 0;
  int n_err = 0;

  vga_fb_arbiter dut (
    .pxclk(pxclk), .rst_n(rst_n), .xaddr(xaddr), .yaddr(yaddr),
    .addr_valid(addr_valid), .vsync(vsync), .pixel(pixel), .pixel_valid(pixel_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .base_wr(base_wr), .base_wdata(base_wdata), .base_active(base_active),
    .frame_start(frame_start), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
  );

  initial pxclk = 1'b0;
  always #5 pxclk = ~pxclk;

  function automatic logic [31:0] init_word(int a);
    case (a)
      0:       return 32'h76543210;
      1:       return 32'hFEDCBA98;
      5:       return 32'hCAFE0005;
      81:      return 32'h0BADF00D;
      'h1234:  return 32'h11223344;
      'h4000:  return 32'hA5A5A5A5;
      'h6000:  return 32'hFFFFFFFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Framebuffer RAM: registered read, byte-strobed write.
  logic [31:0] ram [0:65535];
  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = init_word(a);
    ram_rdata = '0;
    forever begin
      @(posedge pxclk);
      if (ram_en) begin
        if (ram_we) begin
          for (int b = 0; b < 4; b++)
            if (ram_wstrb[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end else ram_rdata <= ram[ram_addr];
      end
    end
  end

  // Reference model: checks every cycle at negedge, then advances its state.
  logic [31:0] mm [0:65535];
  initial begin
    logic [15:0] m_pend, m_act, faddr;
    logic        m_vsq, fetch, rd_exp;
    logic [31:0] m_word, rd_val;
    logic [1:0]  pv;
    logic [3:0]  pp [0:1];
    logic [3:0]  curpix;
    for (int a = 0; a < 65536; a++) mm[a] = init_word(a);
    m_pend = '0; m_act = '0; m_vsq = 1'b0; m_word = '0;
    rd_exp = 1'b0; rd_val = '0; pv = '0; pp[0] = '0; pp[1] = '0;
    forever begin
      @(negedge pxclk);
      if (!rst_n) begin
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_gnt", 32'(cpu_gnt), 0);
        chk("rst_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_pixel_valid", 32'(pixel_valid), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        m_pend = '0; m_act = '0; m_vsq = 1'b0; m_word = '0;
        rd_exp = 1'b0; pv = '0; pp[0] = '0; pp[1] = '0;
      end else begin
        fetch = addr_valid && (xaddr % 8 == 0);
        faddr = 16'(int'(m_act) + int'(yaddr) * 80 + int'(xaddr) / 8);
        chk("m_ram_en", 32'(ram_en), 32'(fetch || cpu_req));
        chk("m_gnt", 32'(cpu_gnt), 32'(!fetch && cpu_req));
        if (fetch) begin
          chk("m_disp_addr", 32'(ram_addr), 32'(faddr));
          chk("m_disp_we", 32'(ram_we), 0);
        end else if (cpu_req) begin
          chk("m_cpu_addr", 32'(ram_addr), 32'(cpu_addr));
          chk("m_cpu_we", 32'(ram_we), 32'(cpu_we));
          if (cpu_we) begin
            chk("m_cpu_wdata", ram_wdata, cpu_wdata);
            chk("m_cpu_wstrb", 32'(ram_wstrb), 32'(cpu_wstrb));
          end
        end
        chk("m_rvalid", 32'(cpu_rvalid), 32'(rd_exp));
        if (rd_exp) chk("m_rdata", cpu_rdata, rd_val);
        chk("m_pixel_valid", 32'(pixel_valid), 32'(pv[1]));
        chk("m_pixel", 32'(pixel), 32'(pp[1]));
        chk("m_frame_start", 32'(frame_start), 32'(vsync && !m_vsq));
        chk("m_base_active", 32'(base_active), 32'(m_act));
        // advance
        if (fetch) m_word = mm[faddr];
        curpix = addr_valid ? 4'(m_word >> (4 * (xaddr % 8))) : 4'h0;
        pv[1] = pv[0]; pp[1] = pp[0];
        pv[0] = addr_valid; pp[0] = curpix;
        rd_exp = !fetch && cpu_req && !cpu_we;
        rd_val = mm[cpu_addr];
        if (!fetch && cpu_req && cpu_we)
          for (int b = 0; b < 4; b++)
            if (cpu_wstrb[b]) mm[cpu_addr][8*b +: 8] = cpu_wdata[8*b +: 8];
        if (vsync && !m_vsq) m_act = m_pend;
        if (base_wr) m_pend = base_wdata;
        m_vsq = vsync;
      end
    end
  end

  task automatic step();
    @(posedge pxclk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; xaddr = '0; yaddr = '0; addr_valid = 1'b0; vsync = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    base_wr = 1'b0; base_wdata = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step(); #1;
    chk("reset_base_active", 32'(base_active), 0);

    // Line 0: word 0 = 0x76543210 must emerge as pixels 0..7.
    for (int i = 0; i < 12; i++) begin
      step();
      addr_valid = (i < 10); xaddr = (i < 10) ? 10'(i) : 10'd0; yaddr = 9'd0;
      #1;
      if (i == 0) chk("fetch_x0y0_addr", 32'(ram_addr), 0);
      if (i >= 2 && i < 10) chk("pix_line0", 32'(pixel), 32'(i - 2));
    end

    // Line 1 with the CPU hammering reads: only fetch cycles deny the grant.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
    for (int i = 0; i < 17; i++) begin
      step();
      addr_valid = 1'b1; xaddr = 10'(i); yaddr = 9'd1;
      #1;
      chk("gnt_pattern", 32'(cpu_gnt), 32'(i % 8 != 0));
      if (i == 8) chk("fetch_x8y1_addr", 32'(ram_addr), 81);
    end
    step(); addr_valid = 1'b0; cpu_req = 1'b0;
    step();

    // Partial write then read back in blanking.
    step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234;
    cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'b0011;
    #1; chk("blank_wr_gnt", 32'(cpu_gnt), 1);
    step(); cpu_we = 1'b0;
    #1; chk("blank_rd_gnt", 32'(cpu_gnt), 1);
    step(); cpu_req = 1'b0;
    #1; chk("rd_rvalid", 32'(cpu_rvalid), 1);
    chk("rd_rdata", cpu_rdata, 32'h1122BEEF);

    // Mid-frame base write, swapped at vsync rise.
    step(); base_wr = 1'b1; base_wdata = 16'h4000;
    step(); base_wr = 1'b0;
    #1; chk("base_before_vsync", 32'(base_active), 0);
    step(); vsync = 1'b1;
    #1; chk("frame_start_pulse", 32'(frame_start), 1);
    chk("base_on_vsync_cycle", 32'(base_active), 0);
    step();
    #1; chk("frame_start_single", 32'(frame_start), 0);
    chk("base_after_vsync", 32'(base_active), 32'h4000);
    step(); vsync = 1'b0;
    step(); addr_valid = 1'b1; xaddr = '0; yaddr = '0;
    #1; chk("fetch_new_base", 32'(ram_addr), 32'h4000);
    step(); addr_valid = 1'b0;

    // base_wr coinciding with the swap cycle.
    step(); base_wr = 1'b1; base_wdata = 16'h5000;
    step(); base_wr = 1'b1; base_wdata = 16'h6000; vsync = 1'b1;
    #1; chk("swap_fs", 32'(frame_start), 1);
    step(); base_wr = 1'b0;
    #1; chk("swap_old_pending", 32'(base_active), 32'h5000);
    step(); vsync = 1'b0;
    step(); vsync = 1'b1;
    step();
    #1; chk("swap_next_frame", 32'(base_active), 32'h6000);
    step(); vsync = 1'b0;

    // Load 0xFFFFFFFF into the pixel word, then reset with a read in flight.
    step(); addr_valid = 1'b1; xaddr = '0; yaddr = '0;
    step(); addr_valid = 1'b0;
    step(); step();
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
    #1; chk("pre_rst_gnt", 32'(cpu_gnt), 1);
    step(); cpu_req = 1'b0; rst_n = 1'b0;
    #1; chk("rst_kills_rvalid", 32'(cpu_rvalid), 0);
    step(); rst_n = 1'b1;
    step(); addr_valid = 1'b1; xaddr = 10'd1; yaddr = '0;
    step(); addr_valid = 1'b0;
    step();
    #1; chk("post_rst_pix_valid", 32'(pixel_valid), 1);
    chk("post_rst_pix_cleared", 32'(pixel), 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
